// File: rtl/send_cmd_pkg.sv
// Shared types and defaults for the command packet streamer.
// Header layout: payload length lives in the low bits of the header word.
package send_cmd_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;
    localparam int CNT_W_DEF  = 8;

    localparam int LEN_LSB = 0;
    localparam int LEN_MSB = 5;

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_WAIT,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/pkt_skid_fifo.sv
// Two-entry show-ahead FIFO holding {eop, sop, data} stream beats.
// Soaks up the one-cycle RAM latency while the sink is stalled.
module pkt_skid_fifo
    import send_cmd_pkg::*;
#(
    parameter int W = DATA_W_DEF + 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign o_valid = (r_count != 2'd0);
    assign w_pop   = i_pop & o_valid;
    assign w_push  = i_push & ((r_count != 2'd2) | w_pop);
    assign o_data  = o_valid ? r_mem[r_rp] : '0;
    assign o_count = r_count;

    // Pointers and occupancy; flush and reset empty the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wp <= ~r_wp;
            if (w_pop)  r_rp <= ~r_rp;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Beat storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end

endmodule

// File: rtl/cmd_packet_streamer.sv
// Reads a length header from command RAM and streams the payload
// words as one sop/eop packet, reporting busy/done and dropped commands.
module cmd_packet_streamer
    import send_cmd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send_cmd,
    input  logic [ADDR_W-1:0] start_ram_addr,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    output logic              st_sop,
    output logic              st_eop,
    input  logic              st_ready,
    output logic              busy,
    output logic              done_pulse,
    output logic [CNT_W-1:0]  cmd_drop_cnt
);

    state_t              r_state;
    state_t              w_next;
    logic                r_cmd_q;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_left;
    logic                r_inf;
    logic                r_inf_sop;
    logic                r_inf_eop;
    logic [CNT_W-1:0]    r_drop;

    logic                w_rise;
    logic [ADDR_W-1:0]   w_len;
    logic [ADDR_W-1:0]   w_left;
    logic [2:0]          w_occ;
    logic                w_pay;
    logic                w_fire;
    logic                w_pop;
    logic                w_busy;
    logic                w_done;
    logic                w_valid;
    logic [1:0]          w_cnt;
    logic [DATA_W+1:0]   w_fdata;

    assign w_rise = send_cmd & ~r_cmd_q;
    assign w_len  = ram_rd_data[LEN_LSB +: ADDR_W];
    assign w_left = (r_state == HDR_WAIT) ? w_len : r_left;
    assign w_pop  = w_valid & st_ready;
    assign w_occ  = {1'b0, w_cnt} + {2'b0, r_inf}
                  - {2'b0, w_pop};

    // The header word is on ram_rd_data during HDR_WAIT, so the
    // first payload read can go out in that same cycle.
    assign w_pay  = ((r_state == HDR_WAIT) || (r_state == STREAM))
                  && (w_left != '0) && (w_occ < 3'd2);
    assign w_fire = (r_state == HDR_RD) | w_pay;

    assign ram_rd_en    = w_fire;
    assign ram_rd_addr  = w_fire ? r_addr : '0;
    assign st_valid     = w_valid;
    assign st_data      = w_fdata[DATA_W-1:0];
    assign st_sop       = w_fdata[DATA_W];
    assign st_eop       = w_fdata[DATA_W+1];
    assign busy         = w_busy;
    assign done_pulse   = w_done;
    assign cmd_drop_cnt = r_drop;

    pkt_skid_fifo #(
        .W (DATA_W + 2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (r_state == DONE),
        .i_push  (r_inf),
        .i_data  ({r_inf_eop, r_inf_sop, ram_rd_data}),
        .i_pop   (st_ready),
        .o_data  (w_fdata),
        .o_valid (w_valid),
        .o_count (w_cnt)
    );

    // State, edge detect, read bookkeeping and drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cmd_q   <= 1'b0;
            r_addr    <= '0;
            r_left    <= '0;
            r_inf     <= 1'b0;
            r_inf_sop <= 1'b0;
            r_inf_eop <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_state   <= w_next;
            r_cmd_q   <= send_cmd;
            if (r_state == IDLE && w_rise)
                r_addr <= start_ram_addr;
            else if (w_fire)
                r_addr <= r_addr + ADDR_W'(1);
            if (w_pay)
                r_left <= w_left - ADDR_W'(1);
            else if (r_state == HDR_WAIT)
                r_left <= w_len;
            r_inf     <= w_pay;
            r_inf_sop <= w_pay & (r_state == HDR_WAIT);
            r_inf_eop <= w_pay & (w_left == ADDR_W'(1));
            if (w_rise && r_state != IDLE && r_drop != '1)
                r_drop <= r_drop + CNT_W'(1);
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_rise) w_next = HDR_RD;
            end
            HDR_RD: begin
                w_busy = 1'b1;
                w_next = HDR_WAIT;
            end
            HDR_WAIT: begin
                w_busy = 1'b1;
                w_next = (w_len == '0) ? DONE : STREAM;
            end
            STREAM: begin
                w_busy = 1'b1;
                if (w_pop && w_fdata[DATA_W+1]) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cmd_packet_streamer.sv
// Directed bench for cmd_packet_streamer with a 1-cycle RAM model.
// Cycle k counts clocks after the edge that samples the send_cmd rise.
module tb_cmd_packet_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        send_cmd;
    logic [5:0]  start_ram_addr;
    logic        ram_rd_en;
    logic [5:0]  ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_sop;
    logic        st_eop;
    logic        st_ready;
    logic        busy;
    logic        done_pulse;
    logic [7:0]  cmd_drop_cnt;

    logic [31:0] mem [64];

    int n_vec = 0;
    int n_err = 0;
    int k;
    int first_v;
    int done_k;
    int n_done;
    logic busy_k1;
    logic pv, pr, ps, pe;
    logic [31:0] pd;
    logic [31:0] bd[$];
    logic        bs[$];
    logic        be[$];
    int          bk[$];
    logic [5:0]  rd_q[$];
    logic [63:0] rp;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    cmd_packet_streamer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .send_cmd       (send_cmd),
        .start_ram_addr (start_ram_addr),
        .ram_rd_en      (ram_rd_en),
        .ram_rd_addr    (ram_rd_addr),
        .ram_rd_data    (ram_rd_data),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_sop         (st_sop),
        .st_eop         (st_eop),
        .st_ready       (st_ready),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .cmd_drop_cnt   (cmd_drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {12'd0, ram_rd_en, ram_rd_addr, st_valid, st_data,
                st_sop, st_eop, busy, done_pulse, cmd_drop_cnt};
    endfunction

    task automatic clr();
        bd.delete(); bs.delete(); be.delete(); bk.delete();
        rd_q.delete();
        first_v = -1; done_k = -1; n_done = 0; busy_k1 = 1'b0;
    endtask

    // Advance to mid-cycle, drive inputs for this cycle, observe.
    task automatic step(input logic c, input logic r);
        @(negedge clk);
        k++;
        send_cmd = c;
        st_ready = r;
        if (k == 1) busy_k1 = busy;
        if (ram_rd_en) rd_q.push_back(ram_rd_addr);
        if (st_valid && first_v < 0) first_v = k;
        if (pv && !pr) begin
            chk("hold_valid", st_valid, 1);
            chk("hold_data", st_data, pd);
            chk("hold_sop", st_sop, ps);
            chk("hold_eop", st_eop, pe);
        end
        if (st_valid && st_ready) begin
            bd.push_back(st_data);
            bs.push_back(st_sop);
            be.push_back(st_eop);
            bk.push_back(k);
        end
        if (done_pulse) begin
            n_done++;
            done_k = k;
        end
        pv = st_valid; pr = st_ready;
        pd = st_data; ps = st_sop; pe = st_eop;
    endtask

    task automatic run_pkt(input logic [5:0] s, input logic [63:0] cp,
                           input logic [63:0] rpat, input int budget);
        clr();
        start_ram_addr = s;
        k = -1;
        step(cp[0], rpat[0]);
        for (int j = 1; j <= budget; j++) begin
            step((j < 64) ? cp[j] : 1'b0, (j < 64) ? rpat[j] : 1'b1);
            if (done_k >= 0 && k >= done_k + 2) break;
        end
        if (done_k < 0) chk("timeout_done", 0, 1);
        send_cmd = 1'b0;
        st_ready = 1'b1;
    endtask

    task automatic chk_pkt(input string tag, input logic [5:0] s,
                           input int n);
        logic [5:0] a;
        chk($sformatf("%s_nbeats", tag), bd.size(), n);
        for (int i = 0; i < n; i++) begin
            a = s + 6'(i + 1);
            chk($sformatf("%s_d%0d", tag, i),
                (i < bd.size()) ? bd[i] : 32'hxxxx_xxxx, mem[a]);
            chk($sformatf("%s_sop%0d", tag, i),
                (i < bs.size()) ? bs[i] : 1'bx, i == 0);
            chk($sformatf("%s_eop%0d", tag, i),
                (i < be.size()) ? be[i] : 1'bx, i == n - 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hD000_0000 + i;
        rst_n = 1'b0; send_cmd = 1'b0; st_ready = 1'b1;
        start_ram_addr = '0; pv = 1'b0; k = 0;
        clr();
        step(0, 1);
        step(0, 1);
        chk("reset_outs", outs(), 0);
        rst_n = 1'b1;
        step(0, 1);

        mem[5] = 32'd3;
        mem[6] = 32'hAAAA_0001;
        mem[7] = 32'hBBBB_0002;
        mem[8] = 32'hCCCC_0003;
        run_pkt(5, 64'h1, '1, 120);
        chk_pkt("t1", 5, 3);
        chk("t1_first_valid", first_v, 4);
        chk("t1_last_beat_k", (bk.size() == 3) ? bk[2] : -1, 6);
        chk("t1_done_k", done_k, 7);
        chk("t1_ndone", n_done, 1);
        chk("t1_busy_k1", busy_k1, 1);
        chk("t1_busy_end", busy, 0);

        rp = '1; rp[5] = 1'b0; rp[6] = 1'b0; rp[8] = 1'b0;
        run_pkt(5, 64'h1, rp, 120);
        chk_pkt("t2", 5, 3);
        chk("t2_k0", (bk.size() > 0) ? bk[0] : -1, 4);
        chk("t2_k1", (bk.size() > 1) ? bk[1] : -1, 7);
        chk("t2_k2", (bk.size() > 2) ? bk[2] : -1, 9);
        chk("t2_done_k", done_k, 10);
        chk("t2_ndone", n_done, 1);

        mem[62] = 32'd3;
        mem[63] = 32'h1111_0063;
        mem[0]  = 32'h2222_0000;
        mem[1]  = 32'h3333_0001;
        run_pkt(62, 64'h1, '1, 120);
        chk_pkt("t3", 62, 3);
        chk("t3_nreads", rd_q.size(), 4);
        chk("t3_rd0", (rd_q.size() > 0) ? rd_q[0] : 6'bx, 62);
        chk("t3_rd1", (rd_q.size() > 1) ? rd_q[1] : 6'bx, 63);
        chk("t3_rd2", (rd_q.size() > 2) ? rd_q[2] : 6'bx, 0);
        chk("t3_rd3", (rd_q.size() > 3) ? rd_q[3] : 6'bx, 1);

        mem[10] = 32'd0;
        run_pkt(10, 64'h1, '1, 120);
        chk("t4_nbeats", bd.size(), 0);
        chk("t4_no_valid", first_v, -1);
        chk("t4_done_k", done_k, 3);

        mem[10] = 32'd1;
        run_pkt(10, 64'h1, '1, 120);
        chk_pkt("t4b", 10, 1);
        chk("t4b_first_valid", first_v, 4);
        chk("t4b_done_k", done_k, 5);

        mem[20] = 32'd8;
        run_pkt(20, 64'b1001001, '1, 120);
        chk_pkt("t5", 20, 8);
        chk("t5_ndone", n_done, 1);
        chk("t5_nreads", rd_q.size(), 9);
        chk("t5_drops", cmd_drop_cnt, 2);

        mem[40] = 32'd63;
        clr();
        start_ram_addr = 6'd40;
        k = -1;
        step(1, 0);
        repeat (300) begin
            step(0, 0);
            step(1, 0);
        end
        chk("sat_drops", cmd_drop_cnt, 255);
        chk("sat_busy", busy, 1);
        pv = 1'b0;
        rst_n = 1'b0;
        step(0, 1);
        chk("sat_rst_outs", outs(), 0);
        rst_n = 1'b1;
        step(0, 1);

        mem[30] = 32'd8;
        clr();
        start_ram_addr = 6'd30;
        k = -1;
        step(1, 1);
        for (int j = 1; j <= 6; j++) step(0, 1);
        rst_n = 1'b0;
        pv = 1'b0;
        step(0, 1);
        chk("t6_rst_outs", outs(), 0);
        rst_n = 1'b1;
        chk("t6_nbeats", bd.size(), 3);
        chk("t6_no_eop", (be.size() > 0) ? (be.sum() with (int'(item))) : 0, 0);
        step(0, 1);
        run_pkt(30, 64'h1, '1, 120);
        chk_pkt("t6_after", 30, 8);
        chk("t6_ndone", n_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
